// File: rtl/vram_pkg.sv
// Shared VRAM geometry, read-port timing and scanout state type.
package vram_pkg;

    localparam int VRAM_ADDR_W           = 13;
    localparam int VRAM_DATA_W           = 16;
    localparam int VRAM_READ_LAT         = 3;
    localparam int SCREEN_WORDS_PER_LINE = 32;
    localparam int SCREEN_LINES          = 256;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } vscan_state_t;

endpackage

// File: rtl/vscan_fifo.sv
// Word buffer between the VRAM read return and the pixel serialiser.
// rd_data always shows the current head entry, so the serialiser can shift straight out of it.
module vscan_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);

endmodule

// File: rtl/vram_scanout.sv
// Scanline fetcher for the VRAM priority port: credit-paced reads, word FIFO, 1-bit pixel serialiser.
// Optional VSCAN_CPU_SLOT_EN inserts a forced idle read cycle after every 4 back-to-back reads.
module vram_scanout
    import vram_pkg::*;
#(
    parameter int WORDS_PER_LINE = SCREEN_WORDS_PER_LINE,
    parameter int LINES          = SCREEN_LINES,
    parameter int READ_LAT       = VRAM_READ_LAT,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [7:0]  line_idx,
    output logic        p_read,
    output logic [12:0] p_addr,
    input  logic [15:0] p_dout,
    output logic        pix_valid,
    output logic        pix,
    input  logic        pix_ready,
    output logic        line_done,
    output logic        overrun
);

    localparam int LINE_W = $clog2(LINES);
    localparam int WSH    = $clog2(WORDS_PER_LINE);
    localparam int CNT_W  = WSH + 1;
    localparam int BIT_W  = $clog2(VRAM_DATA_W);
    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CW     = $clog2(FIFO_DEPTH + READ_LAT + 1) + 1;

    vscan_state_t           state_q, state_d;
    logic [VRAM_ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   p_read_q, p_read_d;
    logic [VRAM_ADDR_W-1:0] p_addr_q, p_addr_d;
    logic [READ_LAT-1:0]    pipe_q, pipe_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [WSH-1:0]         pop_cnt_q, pop_cnt_d;
    logic                   line_done_q, line_done_d;
    logic                   overrun_q, overrun_d;

    logic                   push, pop, handshake, last_pop;
    logic [VRAM_DATA_W-1:0] head;
    logic [FCW-1:0]         fifo_count;
    logic                   fifo_empty;
    logic [CW-1:0]          occ_next, infl_next;
    logic                   credit_ok, fetching, slot_block;
    logic [VRAM_ADDR_W-1:0] base_cur;
    logic [CNT_W-1:0]       cnt_cur;

    vscan_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (VRAM_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (p_dout),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // The serialiser shifts out of the FIFO head; the word is popped only with its last bit.
    assign push      = pipe_q[READ_LAT-1];
    assign pix_valid = !fifo_empty;
    assign pix       = pix_valid & head[bit_idx_q];
    assign handshake = pix_valid && pix_ready;
    assign pop       = handshake && (bit_idx_q == BIT_W'(VRAM_DATA_W - 1));
    assign last_pop  = pop && (pop_cnt_q == WSH'(WORDS_PER_LINE - 1));

    // Credits are judged on next-cycle occupancy so the registered p_read can never overfill the FIFO.
    always_comb begin
        occ_next  = CW'(fifo_count) + CW'(push) - CW'(pop);
        infl_next = CW'(p_read_q);
        for (int i = 0; i < READ_LAT - 1; i++) begin
            infl_next = infl_next + CW'(pipe_q[i]);
        end
        credit_ok = (occ_next + infl_next) < CW'(FIFO_DEPTH);
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        p_read_d    = 1'b0;
        p_addr_d    = p_addr_q;
        pipe_d      = {pipe_q[READ_LAT-2:0], p_read_q};
        bit_idx_d   = handshake ? bit_idx_q + 1'b1 : bit_idx_q;
        pop_cnt_d   = pop ? pop_cnt_q + 1'b1 : pop_cnt_q;
        line_done_d = 1'b0;
        overrun_d   = overrun_q | (line_start && (state_q != IDLE));
        fetching    = 1'b0;
        base_cur    = base_q;
        cnt_cur     = cnt_q;

        case (state_q)
            IDLE: begin
                if (line_start) begin
                    state_d   = FETCH;
                    base_d    = VRAM_ADDR_W'(line_idx[LINE_W-1:0]) << WSH;
                    base_cur  = base_d;
                    cnt_d     = '0;
                    cnt_cur   = '0;
                    bit_idx_d = '0;
                    pop_cnt_d = '0;
                    fetching  = 1'b1;
                end
            end
            FETCH: begin
                fetching = 1'b1;
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d     = IDLE;
                    line_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fetching && (cnt_cur < CNT_W'(WORDS_PER_LINE)) && credit_ok && !slot_block) begin
            p_read_d = 1'b1;
            p_addr_d = base_cur + VRAM_ADDR_W'(cnt_cur);
            cnt_d    = cnt_cur + 1'b1;
            if (cnt_cur == CNT_W'(WORDS_PER_LINE - 1)) begin
                state_d = DRAIN;
            end
        end
    end

`ifdef VSCAN_CPU_SLOT_EN
    logic [2:0] run_q, run_d;

    // run_q counts the back-to-back p_read cycles ending in the current one.
    assign slot_block = (run_q == 3'd4);
    assign run_d      = p_read_d ? run_q + 3'd1 : 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    assign slot_block = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            p_read_q    <= 1'b0;
            p_addr_q    <= '0;
            pipe_q      <= '0;
            bit_idx_q   <= '0;
            pop_cnt_q   <= '0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            p_read_q    <= p_read_d;
            p_addr_q    <= p_addr_d;
            pipe_q      <= pipe_d;
            bit_idx_q   <= bit_idx_d;
            pop_cnt_q   <= pop_cnt_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign p_read    = p_read_q;
    assign p_addr    = p_addr_q;
    assign line_done = line_done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout: a VRAM model with 3-cycle read latency, and a line-level
// reference of the expected address sequence and pixel stream.
module tb_vram_scanout;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_start;
    logic [7:0]  line_idx;
    logic        p_read;
    logic [12:0] p_addr;
    logic [15:0] p_dout;
    logic        pix_valid;
    logic        pix;
    logic        pix_ready;
    logic        line_done;
    logic        overrun;

    vram_scanout dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .line_idx   (line_idx),
        .p_read     (p_read),
        .p_addr     (p_addr),
        .p_dout     (p_dout),
        .pix_valid  (pix_valid),
        .pix        (pix),
        .pix_ready  (pix_ready),
        .line_done  (line_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] vram [8192];
    logic        rd_v [3];
    logic [12:0] rd_a [3];
    logic        prev_read;
    logic [12:0] prev_addr;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   base, rd_count, hs_count, first_rd, first_pv;
    int   min_addr, max_addr, run_len, max_run;
    logic active = 1'b0;
    logic expect_done = 1'b0;
    logic stall_pending = 1'b0;
    logic held_pix = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Evaluates the current cycle against the line reference (inputs already driven).
    task automatic monitor();
        cyc++;
        if (expect_done) begin
            check("line_done_timing", 32'(line_done), 32'd1);
            expect_done = 1'b0;
        end
        if (line_done) begin
            check("line_done_after_512", 32'(hs_count), 32'd512);
            active = 1'b0;
        end
        if (active) begin
            if (p_read) begin
                if (first_rd < 0) first_rd = cyc;
                check("p_addr", 32'(p_addr), 32'(base + rd_count));
                rd_count++;
                check("read_count_le_32", 32'(rd_count <= 32), 32'd1);
                if (int'(p_addr) < min_addr) min_addr = int'(p_addr);
                if (int'(p_addr) > max_addr) max_addr = int'(p_addr);
            end
            run_len = p_read ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            check("credit_bound", 32'((rd_count - hs_count / 16) <= FIFO_DEPTH), 32'd1);
            if (stall_pending) begin
                check("pix_valid_held", 32'(pix_valid), 32'd1);
                check("pix_held", 32'(pix), 32'(held_pix));
            end
            if (pix_valid && first_pv < 0) first_pv = cyc;
            stall_pending = pix_valid && !pix_ready;
            held_pix = pix;
            if (pix_valid && pix_ready) begin
                check("pix", 32'(pix), 32'(vram[base + hs_count / 16][hs_count % 16]));
                hs_count++;
                if (hs_count == 512) expect_done = 1'b1;
            end
        end
    endtask

    // One clock: check this cycle, advance, then return the VRAM data for the read 3 cycles back.
    task automatic tick();
        monitor();
        prev_read = p_read;
        prev_addr = p_addr;
        @(posedge clk);
        #1;
        rd_v[2] = rd_v[1];
        rd_a[2] = rd_a[1];
        rd_v[1] = rd_v[0];
        rd_a[1] = rd_a[0];
        rd_v[0] = prev_read;
        rd_a[0] = prev_addr;
        p_dout  = rd_v[2] ? vram[rd_a[2]] : 16'($urandom);
    endtask

    task automatic start_line(input int idx);
        line_idx      = 8'(idx);
        line_start    = 1'b1;
        base          = (idx % 256) * 32;
        rd_count      = 0;
        hs_count      = 0;
        first_rd      = -1;
        first_pv      = -1;
        min_addr      = 1 << 20;
        max_addr      = -1;
        run_len       = 0;
        max_run       = 0;
        stall_pending = 1'b0;
        expect_done   = 1'b0;
        active        = 1'b1;
        tick();
        line_start    = 1'b0;
    endtask

    // random_ready=0 keeps pix_ready high; otherwise it toggles randomly each cycle.
    task automatic run_to_done(input int random_ready);
        int budget;
        budget = 4000;
        while (active && budget > 0) begin
            pix_ready = (random_ready != 0) ? 1'($urandom) : 1'b1;
            tick();
            budget--;
        end
        check("line_completes", 32'(active), 32'd0);
        active = 1'b0;
        check("reads_per_line", 32'(rd_count), 32'd32);
        check("pixels_per_line", 32'(hs_count), 32'd512);
        check("line_done_one_cycle", 32'(line_done), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        line_start = 1'b0;
        line_idx   = 8'd0;
        pix_ready  = 1'b0;
        p_dout     = 16'd0;
        for (int i = 0; i < 3; i++) begin
            rd_v[i] = 1'b0;
            rd_a[i] = 13'd0;
        end
        for (int i = 0; i < 8192; i++) vram[i] = 16'($urandom);
        vram[0] = 16'h0001;

        // Reset state
        repeat (3) tick();
        check("rst_p_read", 32'(p_read), 32'd0);
        check("rst_p_addr", 32'(p_addr), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix", 32'(pix), 32'd0);
        check("rst_line_done", 32'(line_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Line 0, display always ready: addresses 0..31, word 0 = 0x0001
        pix_ready = 1'b1;
        start_line(0);
        run_to_done(0);
        check("first_pix_latency", 32'(first_pv - first_rd), 32'd4);
        check("line0_min_addr", 32'(min_addr), 32'd0);
        check("line0_max_addr", 32'(max_addr), 32'd31);
        check("max_consecutive_reads", 32'(max_run <= 4), 32'd1);
        repeat (3) tick();

        // Last line: addresses 8160..8191, random backpressure
        start_line(255);
        run_to_done(1);
        check("line255_min_addr", 32'(min_addr), 32'd8160);
        check("line255_max_addr", 32'(max_addr), 32'd8191);
        repeat (3) tick();

        // Display stalled from the start: only FIFO_DEPTH reads may be outstanding
        pix_ready = 1'b0;
        start_line(7);
        repeat (20) tick();
        check("stall_reads_issued", 32'(rd_count), 32'(FIFO_DEPTH));
        check("stall_p_read_low", 32'(p_read), 32'd0);
        check("stall_pix_valid", 32'(pix_valid), 32'd1);
        run_to_done(1);
        repeat (3) tick();

        // line_start during FETCH: flagged, current line unaffected
        check("pre_overrun", 32'(overrun), 32'd0);
        pix_ready = 1'b1;
        start_line(3);
        repeat (10) tick();
        line_idx   = 8'd99;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        run_to_done(0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        repeat (3) tick();

        // Reset mid-FETCH with reads in flight; stale VRAM returns must be ignored
        pix_ready = 1'b1;
        start_line(9);
        tick();
        active = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_p_read", 32'(p_read), 32'd0);
        check("midrst_pix_valid", 32'(pix_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("postrst_p_read", 32'(p_read), 32'd0);
            check("postrst_pix_valid", 32'(pix_valid), 32'd0);
            check("postrst_line_done", 32'(line_done), 32'd0);
        end
        check("postrst_overrun", 32'(overrun), 32'd0);
        start_line(9);
        run_to_done(1);
        repeat (3) tick();

        // A few random lines with random backpressure
        for (int n = 0; n < 2; n++) begin
            start_line(int'($urandom_range(0, 255)));
            run_to_done(1);
            repeat (2) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vram_scanout.md
Name: vram_scanout

Overview:
- Display-side controller for the video RAM's priority read port.
- Per scanline, issues the 32 word reads (512 px / 16) for that line and absorbs the fixed 3-cycle read latency. Words are buffered in a small credit-controlled FIFO and serialised to a 1-bit pixel stream with valid/ready handshake.
- Paces reads so the CPU port (blocked whenever p_read is high) is starved only while the FIFO has space.

Parameters:
- WORDS_PER_LINE, 32, words fetched per line; address stride.
- LINES, 256, valid line indices 0..LINES-1.
- READ_LAT, 3, cycles from p_read high to matching p_dout valid.
- FIFO_DEPTH, 4, word buffer entries (power of 2, >= READ_LAT+1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- line_start  in  1  one-cycle pulse requesting fetch of line line_idx.
- line_idx  in  8  line number, sampled on line_start.
- p_read  out  1  read request to VRAM priority port.
- p_addr  out  13  VRAM word address.
- p_dout  in  16  VRAM read data, valid READ_LAT cycles after p_read.
- pix_valid  out  1  pix holds a valid pixel.
- pix  out  1  current pixel, 1 = black.
- pix_ready  in  1  display consumes pixel when pix_valid && pix_ready.
- line_done  out  1  one-cycle pulse after last pixel of a line is consumed.
- overrun  out  1  sticky: line_start arrived while not IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE; p_read=0, p_addr=0, pix_valid=0, pix=0, line_done=0, overrun=0; FIFO, in-flight pipe, and all counters cleared. Reset mid-line discards all in-flight data; stale p_dout returns after release are ignored because the in-flight pipe is zero.
- States: IDLE -> FETCH on line_start; FETCH -> DRAIN after the 32nd read is issued; DRAIN -> IDLE in the cycle the last pixel handshakes, with line_done=1 that cycle.
- On line_start in IDLE: base = line_idx*32 (13-bit); word counter = 0. line_idx >= LINES: treated modulo 256; no special case.
- Read issue (FETCH):
  - p_read=1 in a cycle iff credits > 0, where credits = FIFO_DEPTH - occupancy - in_flight.
  - p_addr = base + word counter, registered together with p_read.
  - Counter increments per issued read.
- In-flight tracking: READ_LAT-deep shift register of issued-read bits. When a bit exits the pipe, p_dout is pushed into the FIFO that cycle. Push never overflows, by construction of the credit rule.
- Serialiser:
  - Pops a word when the shifter is empty or its last bit is consumed.
  - Emits bit 0 first (leftmost pixel), then bit 1 .. bit 15.
  - pix_valid stays high while the shifter holds bits; pix and pix_valid are held stable until handshake.
  - Pop and push in the same cycle are both legal.
- Empty FIFO with shifter drained mid-line: pix_valid=0 (underrun gap); no error is flagged.
- line_start outside IDLE: ignored; overrun set and held until reset.
- Throughput: with pix_ready tied high, one word per 16 cycles is consumed and the FIFO refills well ahead.
- line_done is asserted only for a complete line, never after a reset.

Optional Feature:
- VSCAN_CPU_SLOT_EN.
- Defined: after every 4 consecutive cycles with p_read=1, the block forces p_read=0 for one cycle, guaranteeing the CPU port a slot at least every 5 cycles. The gap counter resets when p_read drops naturally.
- Undefined: no forced gaps; reads are limited only by credits.

Decomposition:
- Shared package vram_pkg:
  - VRAM_ADDR_W=13, VRAM_DATA_W=16, VRAM_READ_LAT=3, SCREEN_WORDS_PER_LINE=32, SCREEN_LINES=256.
  - Enumerated state type vscan_state_t {IDLE, FETCH, DRAIN}.
- One sub-module, vscan_fifo: synchronous FIFO, FIFO_DEPTH x 16, push/pop/count/empty, async active-low reset.

Test Plan:
- Reset, then line_start with line_idx=0 and pix_ready=1 -> p_addr sequence 0..31. First pix_valid 4 cycles after first p_read. VRAM word 0 = 16'h0001 yields pix 1 then fifteen 0s. line_done fires once, after 512 handshakes.
- line_idx=255 -> addresses 8160..8191; no wrap beyond 8191.
- pix_ready held low after start -> exactly FIFO_DEPTH reads issued, then p_read stays 0. Release pix_ready -> reads resume one per popped word, with no data lost or duplicated against a reference model.
- line_start pulsed during FETCH -> overrun=1 and stays 1; current line addresses and pixels unaffected.
- rst_n asserted mid-FETCH with 2 reads in flight, released 1 cycle later -> no FIFO push, pix_valid=0, IDLE, next line fetches cleanly.
- With VSCAN_CPU_SLOT_EN and pix_ready=1 from empty -> no more than 4 consecutive p_read=1 cycles observed across a full line.
